fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 86 ++++++++
 tb/tb_fetch_unit.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch unit: a two-state fetch/hold handshake between instruction memory
// and the decoder, with next-PC selection (sequential / beq / bne / j) on consume.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        branch,
  input  logic        bne,
  input  logic        jump,
  input  logic        zero,
  output logic [31:0] pc,
  output logic [31:0] pcplus4
);

  typedef enum logic {FETCH = 1'b0, HOLD = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] br_off, br_tgt, j_tgt, npc;
  logic        taken;

  assign pcplus4   = pc_q + 32'd4;
  assign pc        = pc_q;
  assign imem_addr = pc_q;
  assign instr     = instr_q;

  // Branch offset is a word count; sign-extend then scale to bytes.
  assign br_off = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
  assign br_tgt = pcplus4 + br_off;
  assign j_tgt  = {pcplus4[31:28], instr_q[25:0], 2'b00};
  assign taken  = (branch & zero) | (bne & ~zero);

  always_comb begin
    npc = pcplus4;
    if (jump)       npc = j_tgt;
    else if (taken) npc = br_tgt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      instr_q <= 32'h00000000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    case (state_q)
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          state_d = HOLD;
          instr_d = imem_rdata;
        end
      end
      HOLD: begin
        instr_valid = 1'b1;
        // Decoder controls are only meaningful on the consuming edge.
        if (instr_ready) begin
          state_d = FETCH;
          pc_d    = npc;
        end
      end
      default: state_d = FETCH;
    endcase
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: transaction-level model compared against the DUT every cycle,
// plus directed scenarios with hand-computed PC values.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        branch, bne, jump, zero;
  logic [31:0] pc, pcplus4;

  int total = 0;
  int bad   = 0;

  fetch_unit #(.RESET_PC(32'h00000000)) dut (
    .clk(clk), .reset(reset),
    .imem_addr(imem_addr), .imem_req(imem_req), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .branch(branch), .bne(bne), .jump(jump), .zero(zero),
    .pc(pc), .pcplus4(pcplus4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Next PC from the architectural rules, using plain integer arithmetic.
  function automatic logic [31:0] model_next(input logic [31:0] p, input logic [31:0] ins,
                                             input logic b, input logic bn,
                                             input logic j, input logic z);
    longint m, p4, off, r;
    m  = 64'h1_0000_0000;
    p4 = (longint'(p) + 4) % m;
    if (j) begin
      r = (p4 - (p4 % 64'h1000_0000)) + (longint'(ins) % 64'h400_0000) * 4;
    end else if ((b && z) || (bn && !z)) begin
      off = longint'(ins) % 65536;
      if (off >= 32768) off = off - 65536;
      r = p4 + off * 4;
    end else begin
      r = p4;
    end
    r = ((r % m) + m) % m;
    return r[31:0];
  endfunction

  // Model: either waiting for memory, or holding one instruction for the decoder.
  logic        m_known = 1'b0;
  logic        m_holding;
  logic [31:0] m_pc, m_instr;

  always @(posedge clk) begin
    if (reset) begin
      m_known   = 1'b1;
      m_holding = 1'b0;
      m_pc      = 32'h00000000;
      m_instr   = 32'h00000000;
    end else if (m_known) begin
      if (!m_holding && imem_ack) begin
        m_holding = 1'b1;
        m_instr   = imem_rdata;
      end else if (m_holding && instr_ready) begin
        m_holding = 1'b0;
        m_pc      = model_next(m_pc, m_instr, branch, bne, jump, zero);
      end
    end
  end

  logic win = 1'b0;
  int   nreq = 0, nval = 0;

  always @(negedge clk) begin
    if (m_known) begin
      chk("imem_req",    {31'd0, imem_req},    {31'd0, !m_holding});
      chk("instr_valid", {31'd0, instr_valid}, {31'd0, m_holding});
      chk("imem_addr",   imem_addr, m_pc);
      chk("pc",          pc,        m_pc);
      chk("pcplus4",     pcplus4,   m_pc + 32'd4);
      chk("instr",       instr,     m_instr);
    end
    if (win) begin
      if (imem_req)    nreq++;
      if (instr_valid) nval++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Memory answers after dly cycles; instr_ready is waved meanwhile and must be ignored.
  task automatic fetch(input logic [31:0] data, input int dly);
    for (int i = 0; i < dly; i++) begin
      imem_ack = 1'b0; instr_ready = 1'b1; imem_rdata = 32'hBAD0BAD0;
      step();
    end
    instr_ready = 1'b0; imem_ack = 1'b1; imem_rdata = data;
    step();
    imem_ack = 1'b0; imem_rdata = 32'h0;
  endtask

  // Decoder consumes after dly cycles; distractor controls and acks while not ready.
  task automatic consume(input int dly, input logic b, input logic bn,
                         input logic j, input logic z);
    for (int i = 0; i < dly; i++) begin
      instr_ready = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hDEADBEEF;
      branch = 1'b1; bne = 1'b1; jump = 1'b1; zero = ~z;
      step();
    end
    imem_ack = 1'b0; instr_ready = 1'b1;
    branch = b; bne = bn; jump = j; zero = z;
    step();
    instr_ready = 1'b0; branch = 1'b0; bne = 1'b0; jump = 1'b0; zero = 1'b0;
  endtask

  initial begin
    reset = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0; instr_ready = 1'b0;
    branch = 1'b0; bne = 1'b0; jump = 1'b0; zero = 1'b0;

    chk("pin_beq",  model_next(32'h10, 32'h1109FFFE, 1, 0, 0, 1), 32'h0000000C);
    chk("pin_bne",  model_next(32'h10, 32'h14000003, 0, 1, 0, 0), 32'h00000020);
    chk("pin_jmp",  model_next(32'h40000000, 32'h08000010, 1, 0, 1, 1), 32'h40000040);
    chk("pin_wrap", model_next(32'hFFFFFFFC, 32'h0, 0, 0, 0, 0), 32'h00000000);

    step(); step();
    reset = 1'b0;
    chk("rst_req",   {31'd0, imem_req}, 32'd1);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_addr",  imem_addr, 32'h0);
    chk("rst_instr", instr, 32'h0);

    fetch(32'h20080005, 0);
    chk("seq_instr", instr, 32'h20080005);
    consume(0, 0, 0, 0, 0);
    chk("seq_pc",   pc, 32'h4);
    chk("seq_addr", imem_addr, 32'h4);

    fetch(32'h10000002, 1); consume(1, 1, 0, 0, 1);
    chk("fwd_beq_pc", pc, 32'h10);
    fetch(32'h1109FFFE, 0); consume(0, 1, 0, 0, 1);
    chk("beq_taken_pc", pc, 32'h0C);
    fetch(32'h20080005, 0); consume(0, 0, 0, 0, 0);
    chk("seq2_pc", pc, 32'h10);
    fetch(32'h14000003, 0); consume(0, 0, 1, 0, 1);
    chk("bne_nt_pc", pc, 32'h14);
    fetch(32'h1000FFFE, 0); consume(0, 1, 0, 0, 1);
    chk("back_pc", pc, 32'h10);
    fetch(32'h14000003, 0); consume(0, 0, 1, 0, 0);
    chk("bne_t_pc", pc, 32'h20);
    fetch(32'h20080005, 0); consume(0, 0, 0, 0, 0);
    chk("seq3_pc", pc, 32'h24);

    // Reset lands on the consuming edge of a taken branch.
    fetch(32'h10000004, 0);
    instr_ready = 1'b1; branch = 1'b1; zero = 1'b1; reset = 1'b1;
    step();
    reset = 1'b0; instr_ready = 1'b0; branch = 1'b0; zero = 1'b0;
    chk("midrst_pc",    pc, 32'h0);
    chk("midrst_req",   {31'd0, imem_req}, 32'd1);
    chk("midrst_valid", {31'd0, instr_valid}, 32'd0);
    chk("midrst_instr", instr, 32'h0);

    fetch(32'h1000FFFE, 0); consume(0, 1, 0, 0, 1);
    chk("wrap_pc",  pc, 32'hFFFFFFFC);
    chk("wrap_p4",  pcplus4, 32'h0);
    fetch(32'h20080005, 0); consume(0, 0, 0, 0, 0);
    chk("wrap_seq", pc, 32'h0);

    // Climb the 256MB regions with jumps to the region's last word.
    for (int k = 0; k < 4; k++) begin
      fetch(32'h0BFFFFFF, 0); consume(0, 0, 0, 1, 0);
      fetch(32'h20080005, 0); consume(0, 0, 0, 0, 0);
    end
    chk("climb_pc", pc, 32'h40000000);
    fetch(32'h08000010, 0); consume(0, 1, 0, 1, 1);
    chk("jmp_prio_pc", pc, 32'h40000040);

    win = 1'b1;
    fetch(32'h20080005, 3);
    chk("stall_instr", instr, 32'h20080005);
    consume(2, 0, 0, 0, 0);
    win = 1'b0;
    chk("stall_nreq", nreq, 32'd4);
    chk("stall_nval", nval, 32'd3);
    chk("stall_pc",   pc, 32'h40000044);

    for (int i = 0; i < 30; i++) begin
      fetch($urandom, $urandom_range(0, 2));
      consume($urandom_range(0, 2), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    step(); step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
